id_resp_matcher: RTL and testbench

//  Consumer stage behind an ID queue holding per-transaction request metadata (meta_t), FIFO-ordered per ID.

---
 rtl/id_resp_matcher_pkg.sv | 12 +
 rtl/id_resp_matcher_if.sv | 49 ++++
 rtl/id_resp_matcher.sv | 147 ++++++++++++++
 tb/tb_id_resp_matcher.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_resp_matcher_pkg.sv
// Shared types for the ID-queue response matcher.
package id_resp_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        OUTPUT
    } state_e;

    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/id_resp_matcher_if.sv
// Bundle of the matcher's response-in, queue-lookup and merged-response-out signals.
interface id_resp_matcher_if #(
    parameter int unsigned ID_WIDTH = 1,
    parameter type         data_t   = logic,
    parameter type         meta_t   = logic
);

    logic [ID_WIDTH-1:0] slv_id;
    data_t               slv_data;
    logic                slv_last;
    logic                slv_valid;
    logic                slv_ready;

    logic [ID_WIDTH-1:0] q_id;
    logic                q_pop;
    logic                q_req;
    meta_t               q_data;
    logic                q_data_valid;
    logic                q_gnt;

    logic [ID_WIDTH-1:0] mst_id;
    data_t               mst_data;
    meta_t               mst_meta;
    logic                mst_last;
    logic                mst_err;
    logic                mst_valid;
    logic                mst_ready;

    // Matcher side.
    modport master (
        input  slv_id, slv_data, slv_last, slv_valid,
        output slv_ready,
        output q_id, q_pop, q_req,
        input  q_data, q_data_valid, q_gnt,
        output mst_id, mst_data, mst_meta, mst_last, mst_err, mst_valid,
        input  mst_ready
    );

    // Environment side: response source, ID queue and downstream sink.
    modport slave (
        output slv_id, slv_data, slv_last, slv_valid,
        input  slv_ready,
        input  q_id, q_pop, q_req,
        output q_data, q_data_valid, q_gnt,
        input  mst_id, mst_data, mst_meta, mst_last, mst_err, mst_valid,
        output mst_ready
    );

endinterface

// File: rtl/id_resp_matcher.sv
// Merges out-of-order responses with the oldest queued metadata for their ID.
// Define ID_RESP_MATCH_CNT_EN to build the saturating mismatch counter.
module id_resp_matcher
    import id_resp_matcher_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = 1,
    parameter type         data_t    = logic,
    parameter type         meta_t    = logic,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [ID_WIDTH-1:0]  slv_id_i,
    input  data_t                slv_data_i,
    input  logic                 slv_last_i,
    input  logic                 slv_valid_i,
    output logic                 slv_ready_o,

    output logic [ID_WIDTH-1:0]  q_id_o,
    output logic                 q_pop_o,
    output logic                 q_req_o,
    input  meta_t                q_data_i,
    input  logic                 q_data_valid_i,
    input  logic                 q_gnt_i,

    output logic [ID_WIDTH-1:0]  mst_id_o,
    output data_t                mst_data_o,
    output meta_t                mst_meta_o,
    output logic                 mst_last_o,
    output logic                 mst_err_o,
    output logic                 mst_valid_o,
    input  logic                 mst_ready_i,

    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    state_e              state_q, state_d;

    logic [ID_WIDTH-1:0] cap_id_q;
    data_t               cap_data_q;
    logic                cap_last_q;

    logic [ID_WIDTH-1:0] mst_id_q;
    data_t               mst_data_q;
    meta_t               mst_meta_q;
    logic                mst_last_q;
    logic                mst_err_q;
    logic                mst_valid_q;

    logic                slv_hs;
    logic                mst_hs;
    logic                lookup_done;

    assign slv_hs      = slv_valid_i & slv_ready_o;
    assign mst_hs      = mst_valid_q & mst_ready_i;
    assign lookup_done = (state_q == LOOKUP) & q_gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (slv_valid_i) state_d = LOOKUP;
            LOOKUP:  if (q_gnt_i) state_d = OUTPUT;
            OUTPUT:  if (mst_ready_i) state_d = slv_valid_i ? LOOKUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Draining the output frees the capture register, so a new beat may enter that cycle.
    always_comb begin
        slv_ready_o = 1'b0;
        q_req_o     = 1'b0;
        unique case (state_q)
            IDLE:    slv_ready_o = 1'b1;
            LOOKUP:  q_req_o     = 1'b1;
            OUTPUT:  slv_ready_o = mst_ready_i;
            default: ;
        endcase
    end

    assign q_id_o  = cap_id_q;
    assign q_pop_o = cap_last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_id_q   <= '0;
            cap_data_q <= '0;
            cap_last_q <= 1'b0;
        end else if (slv_hs) begin
            cap_id_q   <= slv_id_i;
            cap_data_q <= slv_data_i;
            cap_last_q <= slv_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mst_id_q    <= '0;
            mst_data_q  <= '0;
            mst_meta_q  <= '0;
            mst_last_q  <= 1'b0;
            mst_err_q   <= 1'b0;
            mst_valid_q <= 1'b0;
        end else if (lookup_done) begin
            mst_id_q    <= cap_id_q;
            mst_data_q  <= cap_data_q;
            mst_meta_q  <= q_data_valid_i ? q_data_i : '0;
            mst_last_q  <= cap_last_q;
            mst_err_q   <= ~q_data_valid_i;
            mst_valid_q <= 1'b1;
        end else if (mst_hs) begin
            mst_valid_q <= 1'b0;
        end
    end

    assign mst_id_o    = mst_id_q;
    assign mst_data_o  = mst_data_q;
    assign mst_meta_o  = mst_meta_q;
    assign mst_last_o  = mst_last_q;
    assign mst_err_o   = mst_err_q;
    assign mst_valid_o = mst_valid_q;

`ifdef ID_RESP_MATCH_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (lookup_done && !q_data_valid_i && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_resp_matcher.sv
// Randomized scoreboard bench for id_resp_matcher with a behavioural ID-queue model.
module tb_id_resp_matcher;

    localparam int unsigned IW = 3;
    localparam int unsigned CW = 2;
`ifdef ID_RESP_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef logic [7:0] data_t;
    typedef logic [7:0] meta_t;
    typedef struct { logic [IW-1:0] id; meta_t meta; } entry_t;
    typedef struct { logic [IW-1:0] id; data_t data; logic last; meta_t meta; logic err; } resp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic [CW-1:0] err_cnt;
    always #5 clk = ~clk;

    id_resp_matcher_if #(.ID_WIDTH(IW), .data_t(data_t), .meta_t(meta_t)) bus ();

    id_resp_matcher #(.ID_WIDTH(IW), .data_t(data_t), .meta_t(meta_t), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .slv_id_i(bus.slv_id), .slv_data_i(bus.slv_data), .slv_last_i(bus.slv_last),
        .slv_valid_i(bus.slv_valid), .slv_ready_o(bus.slv_ready),
        .q_id_o(bus.q_id), .q_pop_o(bus.q_pop), .q_req_o(bus.q_req),
        .q_data_i(bus.q_data), .q_data_valid_i(bus.q_data_valid), .q_gnt_i(bus.q_gnt),
        .mst_id_o(bus.mst_id), .mst_data_o(bus.mst_data), .mst_meta_o(bus.mst_meta),
        .mst_last_o(bus.mst_last), .mst_err_o(bus.mst_err), .mst_valid_o(bus.mst_valid),
        .mst_ready_i(bus.mst_ready),
        .err_cnt_o(err_cnt)
    );

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    int gnt_mode = 0;  // 0 random, 1 hold low, 2 hold high
    int rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high
    logic [IW-1:0] acc_id = '0;
    logic acc_last = 1'b0;

    entry_t emu_q[$];  // contents of the emulated id_queue, driven by the DUT's lookups
    entry_t ref_q[$];  // reference queue, updated at beat acceptance by the matching rules
    resp_t  exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_wait(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    function automatic int find_id(input entry_t q[$], input logic [IW-1:0] id);
        foreach (q[i]) if (q[i].id == id) return i;
        return -1;
    endfunction

    task automatic push(input logic [IW-1:0] id, input meta_t m);
        entry_t e;
        e.id = id;
        e.meta = m;
        emu_q.push_back(e);
        ref_q.push_back(e);
    endtask

    task automatic send(input logic [IW-1:0] id, input data_t d, input logic last);
        resp_t e;
        int idx;
        int n;
        @(negedge clk); #1;
        bus.slv_id = id;
        bus.slv_data = d;
        bus.slv_last = last;
        bus.slv_valid = 1'b1;
        n = 0;
        while (!bus.slv_ready) begin
            if (n == 200) begin
                fail_wait("send_accept");
                bus.slv_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
            n++;
        end
        idx = find_id(ref_q, id);
        e.id = id;
        e.data = d;
        e.last = last;
        if (idx >= 0) begin
            e.meta = ref_q[idx].meta;
            e.err = 1'b0;
            if (last) ref_q.delete(idx);
        end else begin
            e.meta = '0;
            e.err = 1'b1;
        end
        exp_q.push_back(e);
        acc_id = id;
        acc_last = last;
        @(posedge clk); #1;
        bus.slv_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_wait("drain");
        repeat (2) @(negedge clk);
    endtask

    // Environment: ID queue responder and downstream sink, both acting on the falling edge.
    initial begin
        logic pend_pop;
        int pend_idx;
        int idx;
        pend_pop = 1'b0;
        pend_idx = 0;
        bus.q_gnt = 1'b0;
        bus.q_data = '0;
        bus.q_data_valid = 1'b0;
        bus.mst_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (pend_pop) emu_q.delete(pend_idx);
            pend_pop = 1'b0;
            idx = find_id(emu_q, bus.q_id);
            bus.q_data_valid = (idx >= 0);
            if (idx >= 0) bus.q_data = emu_q[idx].meta;
            else bus.q_data = 8'($urandom);
            bus.q_gnt = !rst_i && (gnt_mode == 2 || (gnt_mode == 0 && $urandom_range(0, 2) != 0));
            bus.mst_ready = (rdy_mode == 2) || (rdy_mode == 0 && $urandom_range(0, 2) != 0);
            if (bus.q_req && bus.q_gnt && bus.q_pop && idx >= 0) begin
                pend_pop = 1'b1;
                pend_idx = idx;
            end
        end
    end

    // Monitor: protocol checks and scoreboard pop, sampled after all drivers have settled.
    initial begin
        logic prev_req, prev_gnt, prev_pop, prev_rst, prev_valid, prev_rdy;
        logic [IW-1:0] prev_qid;
        logic [21:0] prev_snap, snap;
        resp_t e;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_pop = 1'b0; prev_rst = 1'b1;
        prev_valid = 1'b0; prev_rdy = 1'b0; prev_qid = '0; prev_snap = '0;
        forever begin
            @(negedge clk); #2;
            snap = {bus.mst_valid, bus.mst_id, bus.mst_data, bus.mst_meta, bus.mst_last, bus.mst_err};
            if (!rst_i && !prev_rst) begin
                if (prev_req && !prev_gnt) begin
                    check("q_req_held", 32'(bus.q_req), 32'(1'b1));
                    check("q_id_held", 32'(bus.q_id), 32'(prev_qid));
                    check("q_pop_held", 32'(bus.q_pop), 32'(prev_pop));
                end
                if (prev_req && prev_gnt) check("grant_to_valid", 32'(bus.mst_valid), 32'(1'b1));
                if (bus.mst_valid && !prev_valid) check("valid_after_grant", 32'(prev_req && prev_gnt), 32'(1'b1));
                if (prev_valid && !prev_rdy) check("mst_stable", 32'(snap), 32'(prev_snap));
            end
            if (!rst_i) begin
                if (bus.q_req && bus.q_gnt) begin
                    check("lookup_id", 32'(bus.q_id), 32'(acc_id));
                    check("lookup_pop", 32'(bus.q_pop), 32'(acc_last));
                end
                if (bus.mst_valid && bus.mst_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(bus.mst_valid), 32'(1'b0));
                    end else begin
                        e = exp_q.pop_front();
                        check("mst_id", 32'(bus.mst_id), 32'(e.id));
                        check("mst_data", 32'(bus.mst_data), 32'(e.data));
                        check("mst_last", 32'(bus.mst_last), 32'(e.last));
                        check("mst_err", 32'(bus.mst_err), 32'(e.err));
                        check("mst_meta", 32'(bus.mst_meta), 32'(e.meta));
                        if (e.err && exp_cnt < (2 ** CW) - 1) exp_cnt++;
                        check("err_cnt", 32'(err_cnt), CNT_EN ? 32'(exp_cnt) : 32'd0);
                    end
                end
                if (bus.mst_valid) check("slv_ready_out", 32'(bus.slv_ready), 32'(bus.mst_ready));
                else check("slv_ready", 32'(bus.slv_ready), 32'(!bus.q_req));
            end
            prev_req = bus.q_req; prev_gnt = bus.q_gnt; prev_pop = bus.q_pop; prev_qid = bus.q_id;
            prev_rst = rst_i; prev_valid = bus.mst_valid; prev_rdy = bus.mst_ready; prev_snap = snap;
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int np;
        bus.slv_id = '0;
        bus.slv_data = '0;
        bus.slv_last = 1'b0;
        bus.slv_valid = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_slv_ready", 32'(bus.slv_ready), 32'(1'b1));
        check("rst_q_req", 32'(bus.q_req), 32'(1'b0));
        check("rst_mst_valid", 32'(bus.mst_valid), 32'(1'b0));
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Two beats on id 2 see meta A; only the last pops, so the next lookup sees B.
        push(3'd2, 8'hA1);
        push(3'd2, 8'hB2);
        send(3'd2, 8'h10, 1'b0);
        send(3'd2, 8'h11, 1'b1);
        send(3'd2, 8'h12, 1'b1);
        drain();
        check("t1_queue_empty", 32'(emu_q.size()), 32'd0);

        // Unqueued id: forwarded with err, zero meta.
        send(3'd5, 8'h20, 1'b1);
        drain();
        check("t2_err_cnt", 32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);

        // Grant withheld for several cycles.
        gnt_mode = 1;
        push(3'd1, 8'hC3);
        send(3'd1, 8'h30, 1'b1);
        repeat (3) @(negedge clk);
        gnt_mode = 2;
        drain();

        // Downstream stall with a waiting beat.
        rdy_mode = 1;
        push(3'd3, 8'h33);
        send(3'd3, 8'h40, 1'b0);
        fork
            send(3'd3, 8'h41, 1'b1);
            begin
                repeat (5) @(negedge clk);
                rdy_mode = 2;
            end
        join
        check("t4_lookup_after_release", 32'(bus.q_req), 32'(1'b1));
        check("t4_valid_dropped", 32'(bus.mst_valid), 32'(1'b0));
        rdy_mode = 0;
        gnt_mode = 0;
        drain();

        // Reset while a lookup is pending.
        gnt_mode = 1;
        push(3'd4, 8'h44);
        send(3'd4, 8'h50, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk); #2;
        exp_cnt = 0;
        check("t5_q_req", 32'(bus.q_req), 32'(1'b0));
        check("t5_mst_valid", 32'(bus.mst_valid), 32'(1'b0));
        check("t5_err_cnt", 32'(err_cnt), 32'd0);
        check("t5_idle_ready", 32'(bus.slv_ready), 32'(1'b1));
        @(negedge clk);
        rst_i = 1'b0;
        gnt_mode = 0;

        // Five mismatches saturate a 2-bit counter.
        for (int i = 0; i < 5; i++) send(3'(6 + (i % 2)), 8'(8'h60 + i), 1'($urandom_range(0, 1)));
        drain();
        check("t6_err_cnt_sat", 32'(err_cnt), CNT_EN ? 32'd3 : 32'd0);

        // Random traffic.
        for (int blk = 0; blk < 12; blk++) begin
            np = $urandom_range(1, 5);
            for (int k = 0; k < np; k++) push(3'($urandom_range(0, 5)), 8'($urandom));
            nb = $urandom_range(6, 14);
            for (int k = 0; k < nb; k++) begin
                send(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            drain();
        end

        check("end_queue_size", 32'(emu_q.size()), 32'(ref_q.size()));
        if (emu_q.size() == ref_q.size()) begin
            foreach (ref_q[i]) begin
                check("end_queue_id", 32'(emu_q[i].id), 32'(ref_q[i].id));
                check("end_queue_meta", 32'(emu_q[i].meta), 32'(ref_q[i].meta));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
